frame_reader: RTL and testbench
===============================

Name: frame_reader

Overview:
- Read-side master for the multi-solver pixel stores.
- After a solve completes, walks the frame in raster order and issues solver-id/address read requests on the multi_solver read port. Pixel p belongs to solver p mod NUM_SOLVERS, at word p div NUM_SOLVERS.
- Returns each 4-bit solver value on a valid/ready pixel stream consumed by the display/framebuffer path.
- Computes no division; ids and addresses are tracked incrementally.

Parameters:
- NUM_SOLVERS, 1, number of interleaved solvers (1..64).
- NUM_COLUMNS, 640, pixels per row.
- NUM_ROWS, 480, rows per frame.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request to stream one frame
- solve_done  in  1  solver-complete flag (multi_solver done)
- rd_solver_id  out  6  solver select to read port
- rd_addr  out  19  word address within selected solver store
- rd_data_in  in  4  signed value from read port
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream accept
- pix_data  out  4  signed pixel value
- pix_eol  out  1  qualifies last pixel of a row
- pix_last  out  1  qualifies last pixel of frame
- busy  out  1  frame in progress
- frame_count  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset (async): state IDLE; rd_solver_id=0, rd_addr=0; pix_valid=0, pix_eol=0, pix_last=0, busy=0, frame_count=0; FIFO empty; col=0, row=0.
- Read port timing:
  - Store output is registered, and the read mux selects on the current id.
  - Cycle A (ADDR): drive id/addr.
  - Cycle D (DATA): keep id and addr unchanged and sample rd_data_in at the end of D.
  - Max fetch rate is one pixel per 2 cycles.
- States:
  - IDLE: start=1 → WAIT. start while busy is ignored.
  - WAIT: busy=1. solve_done=1 → ADDR. Otherwise hold.
  - ADDR → DATA (always).
  - DATA: write the sample plus eol/last tags into the FIFO, then advance counters.
    - Last pixel → FLUSH.
    - Else if FIFO space remains → ADDR.
    - Else → STALL.
  - STALL: → ADDR once the FIFO has a free entry.
  - FLUSH: once the FIFO is empty → IDLE, frame_count += 1, busy=0.
- Counter advance after each pixel:
  - id: if id==NUM_SOLVERS-1 then id=0 and addr+=1; else id+=1.
  - col: if col==NUM_COLUMNS-1 then col=0 and row+=1; else col+=1.
  - The pixel is tagged eol when col==NUM_COLUMNS-1, and last when additionally row==NUM_ROWS-1.
  - id/addr reset to 0 at each frame start.
- Output FIFO:
  - 2 entries. Head drives pix_data/pix_eol/pix_last, and pix_valid = not empty.
  - Pop on pix_valid & pix_ready.
  - A simultaneous push and pop in the same cycle is legal with 1 entry free.
  - A fetch (ADDR) is entered only if occupancy < 2 at that cycle. If the FIFO is full when DATA ends, the fetch must not have started.
  - pix_data/pix_eol/pix_last must stay stable while pix_valid & !pix_ready.
- Abort: solve_done falling while in ADDR/DATA/STALL/FLUSH (a new solve was started):
  - Next cycle: IDLE, FIFO flushed, pix_valid=0, busy=0.
  - frame_count does not increment and no pix_last is emitted.
- Widths: addr max = ceil(NUM_COLUMNS*NUM_ROWS/NUM_SOLVERS)-1, which must fit in 19 bits. row/col counters are 10 bits each.

Test Plan:
- Address pattern: NUM_SOLVERS=3, 4x2 frame, pix_ready=1, solve_done=1, start pulse → (id,addr) sequence (0,0),(1,0),(2,0),(0,1),(1,1),(2,1),(0,2),(1,2). Each pair held 2 cycles. Values returned by the bench's model store appear on pix_data in order. eol on pixels 3 and 7, last on 7. frame_count=1.
- Gated start: start with solve_done=0 for 20 cycles → busy=1, no reads issued and no pix_valid. Raise solve_done → streaming begins within 2 cycles.
- Backpressure: pix_ready=0 → exactly 2 pixels queued, then no further ADDR and id/addr frozen. Release → stream resumes with no loss or duplication, and the head stays stable while stalled.
- Signed data: store values -1, 7, -8, 0 → pix_data 4'hF, 4'h7, 4'h8, 4'h0.
- Abort: drop solve_done mid-frame → next cycle pix_valid=0, busy=0, frame_count unchanged. A new start streams from (0,0).
- Async reset asserted mid-DATA without a clock edge → all outputs at reset values immediately.

Source files
------------

// File: rtl/frame_reader.sv
// Raster-order read master for the interleaved solver stores; streams each
// 4-bit solver value out through a 2-entry valid/ready FIFO.
//
//   state  | meaning
//   IDLE   | waiting for start
//   WAIT   | frame requested, waiting for solve_done
//   ADDR   | id/addr driven, store output registering
//   DATA   | store output valid, sampled at end of cycle
//   STALL  | FIFO full, holding until an entry frees
//   FLUSH  | all pixels fetched, draining FIFO
module frame_reader #(
    parameter int NUM_SOLVERS = 1,
    parameter int NUM_COLUMNS = 640,
    parameter int NUM_ROWS    = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        solve_done,
    output logic [5:0]  rd_solver_id,
    output logic [18:0] rd_addr,
    input  logic [3:0]  rd_data_in,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [3:0]  pix_data,
    output logic        pix_eol,
    output logic        pix_last,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam logic [5:0] ID_MAX  = 6'(NUM_SOLVERS - 1);
    localparam logic [9:0] COL_MAX = 10'(NUM_COLUMNS - 1);
    localparam logic [9:0] ROW_MAX = 10'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_DATA,
        S_STALL,
        S_FLUSH
    } state_t;

    state_t      state;
    logic [9:0]  col;
    logic [9:0]  row;

    logic [3:0]  fifo_data [2];
    logic [1:0]  fifo_eol;
    logic [1:0]  fifo_last;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_count;
    logic [1:0]  count_next;

    logic        active;
    logic        abort;
    logic        push;
    logic        pop;
    logic        cur_eol;
    logic        cur_last;
    logic        has_space;

    assign pix_valid = (fifo_count != 2'd0);
    assign pix_data  = fifo_data[rd_ptr];
    assign pix_eol   = fifo_eol[rd_ptr];
    assign pix_last  = fifo_last[rd_ptr];

    // A drop of solve_done mid-frame means a new solve has begun; the
    // partially read frame is stale and must be discarded.
    assign active    = (state == S_ADDR) || (state == S_DATA) ||
                       (state == S_STALL) || (state == S_FLUSH);
    assign abort     = active && !solve_done;
    assign push      = (state == S_DATA) && !abort;
    assign pop       = pix_valid && pix_ready;
    assign cur_eol   = (col == COL_MAX);
    assign cur_last  = cur_eol && (row == ROW_MAX);

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 2'd1;
        end else if (pop && !push) begin
            count_next = fifo_count - 2'd1;
        end
    end

    // Space is judged after this cycle's push/pop so a fetch only starts
    // when its sample is guaranteed a slot.
    assign has_space = (count_next != 2'd2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rd_solver_id <= 6'd0;
            rd_addr      <= 19'd0;
            col          <= 10'd0;
            row          <= 10'd0;
            busy         <= 1'b0;
            frame_count  <= 16'd0;
            fifo_data[0] <= 4'd0;
            fifo_data[1] <= 4'd0;
            fifo_eol     <= 2'b00;
            fifo_last    <= 2'b00;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_count   <= 2'd0;
        end else if (abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rd_data_in;
                fifo_eol[wr_ptr]  <= cur_eol;
                fifo_last[wr_ptr] <= cur_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= count_next;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_WAIT;
                        busy         <= 1'b1;
                        rd_solver_id <= 6'd0;
                        rd_addr      <= 19'd0;
                        col          <= 10'd0;
                        row          <= 10'd0;
                    end
                end
                S_WAIT: begin
                    if (solve_done) begin
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    state <= S_DATA;
                end
                S_DATA: begin
                    if (rd_solver_id == ID_MAX) begin
                        rd_solver_id <= 6'd0;
                        rd_addr      <= rd_addr + 19'd1;
                    end else begin
                        rd_solver_id <= rd_solver_id + 6'd1;
                    end
                    if (cur_eol) begin
                        col <= 10'd0;
                        row <= row + 10'd1;
                    end else begin
                        col <= col + 10'd1;
                    end
                    if (cur_last) begin
                        state <= S_FLUSH;
                    end else if (has_space) begin
                        state <= S_ADDR;
                    end else begin
                        state <= S_STALL;
                    end
                end
                S_STALL: begin
                    if (has_space) begin
                        state <= S_ADDR;
                    end
                end
                S_FLUSH: begin
                    if (fifo_count == 2'd0) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: 3 solvers, 4x2 frame, registered model store.
module tb_frame_reader;

    localparam int NS   = 3;
    localparam int NC   = 4;
    localparam int NR   = 2;
    localparam int NPIX = NC * NR;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        solve_done = 1'b0;
    logic        pix_ready = 1'b0;
    logic [5:0]  rd_solver_id;
    logic [18:0] rd_addr;
    logic [3:0]  rd_data_in;
    logic        pix_valid;
    logic [3:0]  pix_data;
    logic        pix_eol;
    logic        pix_last;
    logic        busy;
    logic [15:0] frame_count;

    int errors = 0;
    int checks = 0;

    int         store_val [NPIX] = '{-1, 7, -8, 0, 3, -3, 5, -6};
    logic [3:0] exp_pix   [NPIX] = '{4'hF, 4'h7, 4'h8, 4'h0, 4'h3, 4'hD, 4'h5, 4'hA};
    int         exp_id    [NPIX] = '{0, 1, 2, 0, 1, 2, 0, 1};
    int         exp_addr  [NPIX] = '{0, 0, 0, 1, 1, 1, 2, 2};
    logic [3:0] store_mem [NPIX];
    logic [3:0] store_q = 4'h0;
    int         model_idx;

    frame_reader #(
        .NUM_SOLVERS(NS),
        .NUM_COLUMNS(NC),
        .NUM_ROWS(NR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .solve_done(solve_done),
        .rd_solver_id(rd_solver_id),
        .rd_addr(rd_addr),
        .rd_data_in(rd_data_in),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data(pix_data),
        .pix_eol(pix_eol),
        .pix_last(pix_last),
        .busy(busy),
        .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    // Model store: registered output selected by the current id/addr.
    assign model_idx  = int'(rd_addr) * NS + int'(rd_solver_id);
    assign rd_data_in = store_q;
    always @(posedge clock) begin
        store_q <= (model_idx < NPIX) ? store_mem[model_idx] : 4'h0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic collect_frame(input int exp_fc);
        int n;
        bit got_last;
        n = 0;
        got_last = 1'b0;
        for (int c = 0; c < 80 && !got_last; c++) begin
            if (pix_valid && pix_ready) begin
                if (n < NPIX) begin
                    check($sformatf("stream_data[%0d]", n), 32'(pix_data), 32'(exp_pix[n]));
                    check($sformatf("stream_eol[%0d]", n), 32'(pix_eol), 32'((n % NC) == NC - 1));
                    check($sformatf("stream_last[%0d]", n), 32'(pix_last), 32'(n == NPIX - 1));
                end
                n++;
                if (pix_last) got_last = 1'b1;
            end
            @(negedge clock);
        end
        check("stream_last_seen", 32'(got_last), 32'd1);
        check("stream_pix_count", 32'(n), 32'(NPIX));
        for (int c = 0; c < 20 && busy; c++) @(negedge clock);
        check("stream_busy_clear", 32'(busy), 32'd0);
        check("stream_frame_count", 32'(frame_count), 32'(exp_fc));
    endtask

    initial begin : stim
        bit bad;
        for (int i = 0; i < NPIX; i++) store_mem[i] = 4'(store_val[i]);

        // Reset values
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_id", 32'(rd_solver_id), 32'd0);
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        reset = 1'b0;
        pix_ready = 1'b1;
        solve_done = 1'b1;

        // Address pattern, full-rate stream
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("ap_busy", 32'(busy), 32'd1);
        check("ap_valid_early", 32'(pix_valid), 32'd0);
        for (int k = 0; k < NPIX; k++) begin
            @(negedge clock);
            check($sformatf("ap_id_a[%0d]", k), 32'(rd_solver_id), 32'(exp_id[k]));
            check($sformatf("ap_addr_a[%0d]", k), 32'(rd_addr), 32'(exp_addr[k]));
            if (k > 0) begin
                check($sformatf("ap_valid[%0d]", k - 1), 32'(pix_valid), 32'd1);
                check($sformatf("ap_data[%0d]", k - 1), 32'(pix_data), 32'(exp_pix[k - 1]));
                check($sformatf("ap_eol[%0d]", k - 1), 32'(pix_eol), 32'(k - 1 == 3));
                check($sformatf("ap_last[%0d]", k - 1), 32'(pix_last), 32'd0);
            end
            @(negedge clock);
            check($sformatf("ap_id_d[%0d]", k), 32'(rd_solver_id), 32'(exp_id[k]));
            check($sformatf("ap_addr_d[%0d]", k), 32'(rd_addr), 32'(exp_addr[k]));
            check($sformatf("ap_gap[%0d]", k), 32'(pix_valid), 32'd0);
        end
        @(negedge clock);
        check("ap_valid[7]", 32'(pix_valid), 32'd1);
        check("ap_data[7]", 32'(pix_data), 32'(exp_pix[7]));
        check("ap_eol[7]", 32'(pix_eol), 32'd1);
        check("ap_last[7]", 32'(pix_last), 32'd1);
        @(negedge clock);
        check("ap_flush_valid", 32'(pix_valid), 32'd0);
        check("ap_flush_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("ap_done_busy", 32'(busy), 32'd0);
        check("ap_frame_count", 32'(frame_count), 32'd1);

        // Gated start, then backpressure on the same frame
        solve_done = 1'b0;
        pix_ready = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (pix_valid || rd_solver_id != 6'd0 || rd_addr != 19'd0) bad = 1'b1;
        end
        check("gate_no_activity", 32'(bad), 32'd0);
        check("gate_busy", 32'(busy), 32'd1);
        solve_done = 1'b1;
        @(negedge clock);
        check("gate_valid_1", 32'(pix_valid), 32'd0);
        @(negedge clock);
        check("gate_valid_2", 32'(pix_valid), 32'd0);
        @(negedge clock);
        check("gate_valid_3", 32'(pix_valid), 32'd1);
        check("gate_data", 32'(pix_data), 32'(exp_pix[0]));
        @(negedge clock);
        @(negedge clock);
        check("bp_id", 32'(rd_solver_id), 32'd2);
        check("bp_addr", 32'(rd_addr), 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (!pix_valid || pix_data != exp_pix[0] || pix_eol || pix_last ||
                rd_solver_id != 6'd2 || rd_addr != 19'd0) bad = 1'b1;
        end
        check("bp_stable", 32'(bad), 32'd0);
        pix_ready = 1'b1;
        collect_frame(2);

        // Abort mid-frame, then restart from (0,0)
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check("ab_p0_valid", 32'(pix_valid), 32'd1);
        check("ab_p0_data", 32'(pix_data), 32'(exp_pix[0]));
        @(negedge clock);
        @(negedge clock);
        check("ab_p1_data", 32'(pix_data), 32'(exp_pix[1]));
        solve_done = 1'b0;
        @(negedge clock);
        check("ab_valid", 32'(pix_valid), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_frame_count", 32'(frame_count), 32'd2);
        solve_done = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("ab_restart_id", 32'(rd_solver_id), 32'd0);
        check("ab_restart_addr", 32'(rd_addr), 32'd0);
        collect_frame(3);

        // Async reset in the middle of a DATA cycle
        pix_ready = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check("ar_pre_id", 32'(rd_solver_id), 32'd1);
        check("ar_pre_valid", 32'(pix_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_valid", 32'(pix_valid), 32'd0);
        check("ar_id", 32'(rd_solver_id), 32'd0);
        check("ar_addr", 32'(rd_addr), 32'd0);
        check("ar_data", 32'(pix_data), 32'd0);
        check("ar_eol", 32'(pix_eol), 32'd0);
        check("ar_last", 32'(pix_last), 32'd0);
        check("ar_fc", 32'(frame_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("ar_post_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
